// File: rtl/cdc_req_ack_arb.sv
// Source-side (clk_a) controller sharing one 4-phase req/ack CDC channel among NUM_REQ requesters.
// Round-robin grant captures a word, holds it stable while busy, and waits on the synchronized ack.
`timescale 1ns/1ps
module cdc_req_ack_arb #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk_a,
  input  logic                       rst_a_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       xfer_req,
  output logic [DATA_W-1:0]          xfer_data,
  output logic [$clog2(NUM_REQ)-1:0] xfer_src,
  input  logic                       xfer_ack_b,
  output logic                       xfer_done,
  output logic                       busy
);

  localparam int SRC_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, REQ_HI, REQ_LO} state_e;

  state_e                 state_q, state_d;
  logic [SRC_W-1:0]       ptr_q, ptr_d;
  logic [SYNC_STAGES-1:0] ack_sync_q, ack_sync_d;
  logic                   xfer_req_q, xfer_req_d;
  logic [DATA_W-1:0]      xfer_data_q, xfer_data_d;
  logic [SRC_W-1:0]       xfer_src_q, xfer_src_d;
  logic                   xfer_done_q, xfer_done_d;

  logic             ack_s;
  logic             found;
  logic             grant;
  logic [SRC_W-1:0] winner;
  logic [SRC_W-1:0] next_ptr;

  // xfer_ack_b is only ever observed through the last synchronizer stage.
  assign ack_sync_d = {ack_sync_q[SYNC_STAGES-2:0], xfer_ack_b};
  assign ack_s      = ack_sync_q[SYNC_STAGES-1];

  // Round-robin search: first valid index at or after ptr, wrapping modulo NUM_REQ.
  always_comb begin
    int idx;
    int nxt;
    // NOTE: every variable assigned here gets a default first so no path leaves it unassigned (no latch).
    found    = 1'b0;
    winner   = '0;
    idx      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = SRC_W'(idx);
      end
    end
    nxt = int'(winner) + 1;
    if (nxt >= NUM_REQ) nxt = 0;
    next_ptr = SRC_W'(nxt);
  end

  assign grant = (state_q == IDLE) && found && !ack_s;

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[winner] = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    xfer_req_d  = xfer_req_q;
    xfer_data_d = xfer_data_q;
    xfer_src_d  = xfer_src_q;
    xfer_done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant) begin
          xfer_data_d = req_data[int'(winner)*DATA_W +: DATA_W];
          xfer_src_d  = winner;
          xfer_req_d  = 1'b1;
          ptr_d       = next_ptr;
          state_d     = REQ_HI;
        end
      end
      REQ_HI: begin
        if (ack_s) begin
          xfer_req_d = 1'b0;
          state_d    = REQ_LO;
        end
      end
      REQ_LO: begin
        if (!ack_s) begin
          xfer_done_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_a or negedge rst_a_n) begin
    if (!rst_a_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      ack_sync_q  <= '0;
      xfer_req_q  <= 1'b0;
      xfer_data_q <= '0;
      xfer_src_q  <= '0;
      xfer_done_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values, independent of statement order.
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      ack_sync_q  <= ack_sync_d;
      xfer_req_q  <= xfer_req_d;
      xfer_data_q <= xfer_data_d;
      xfer_src_q  <= xfer_src_d;
      xfer_done_q <= xfer_done_d;
    end
  end

  assign xfer_req  = xfer_req_q;
  assign xfer_data = xfer_data_q;
  assign xfer_src  = xfer_src_q;
  assign xfer_done = xfer_done_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_cdc_req_ack_arb.sv
// Scoreboard bench for cdc_req_ack_arb: stimulus pushes expected (src,data) per grant,
// a monitor pops and compares on each new xfer_req; a clk_b responder models the far side.
`timescale 1ns/1ps
module tb_cdc_req_ack_arb;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
  localparam int SRC_W   = 2;
  localparam int N_RAND  = 150;

  typedef struct packed {
    logic [SRC_W-1:0]  src;
    logic [DATA_W-1:0] data;
  } xfer_t;

  logic                      clk_a = 1'b0;
  logic                      clk_b = 1'b0;
  logic                      rst_a_n;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      xfer_req;
  logic [DATA_W-1:0]         xfer_data;
  logic [SRC_W-1:0]          xfer_src;
  logic                      xfer_ack_b;
  logic                      xfer_done;
  logic                      busy;

  logic       resp_en;
  logic       resp_ack;
  logic       manual_ack;
  int         resp_delay;
  logic [1:0] req_sync_b;

  xfer_t exp_q[$];
  int    checks      = 0;
  int    errors      = 0;
  int    grants_seen = 0;
  int    dones_seen  = 0;

  always #5 clk_a = ~clk_a;
  always #7 clk_b = ~clk_b;

  assign xfer_ack_b = resp_en ? resp_ack : manual_ack;

  cdc_req_ack_arb #(
    .NUM_REQ(NUM_REQ),
    .DATA_W(DATA_W),
    .SYNC_STAGES(2)
  ) dut (
    .clk_a(clk_a),
    .rst_a_n(rst_a_n),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .xfer_req(xfer_req),
    .xfer_data(xfer_data),
    .xfer_src(xfer_src),
    .xfer_ack_b(xfer_ack_b),
    .xfer_done(xfer_done),
    .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // clk_b side: 2-flop synchronizer on xfer_req, ack follows it after resp_delay clk_b cycles.
  always_ff @(posedge clk_b or negedge rst_a_n) begin
    if (!rst_a_n) req_sync_b <= 2'b00;
    else          req_sync_b <= {req_sync_b[0], xfer_req};
  end

  initial begin
    resp_ack = 1'b0;
    forever begin
      @(posedge clk_b);
      #1;
      if (!rst_a_n) resp_ack = 1'b0;
      else if (resp_en && (req_sync_b[1] != resp_ack)) begin
        repeat (resp_delay) @(posedge clk_b);
        #1;
        resp_ack = rst_a_n ? req_sync_b[1] : 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard on every new request, checks hold and one-hot properties.
  initial begin
    logic             prev_req;
    logic             prev_busy;
    logic [DATA_W-1:0] prev_data;
    logic [SRC_W-1:0]  prev_src;
    xfer_t            e;
    prev_req  = 1'b0;
    prev_busy = 1'b0;
    prev_data = '0;
    prev_src  = '0;
    forever begin
      @(negedge clk_a);
      if (rst_a_n) begin
        if (xfer_req && !prev_req) begin
          grants_seen++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_grant: src=%0d data=0x%0h, expected no grant", xfer_src, xfer_data);
          end else begin
            e = exp_q.pop_front();
            check("grant_src", 32'(xfer_src), 32'(e.src));
            check("grant_data", 32'(xfer_data), 32'(e.data));
          end
        end
        if (prev_busy && busy) begin
          check("hold_data", 32'(xfer_data), 32'(prev_data));
          check("hold_src", 32'(xfer_src), 32'(prev_src));
        end
        if (req_ready != '0) begin
          checks++;
          if (!$onehot(req_ready) || busy) begin
            errors++;
            $display("FAIL ready_onehot_idle: ready=%b busy=%b, expected one-hot while idle", req_ready, busy);
          end
        end
        if (xfer_done) begin
          dones_seen++;
          check("done_idle", 32'(busy), 32'd0);
        end
      end
      prev_req  = xfer_req;
      prev_busy = busy;
      prev_data = xfer_data;
      prev_src  = xfer_src;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_a);
    #1;
  endtask

  task automatic do_reset();
    rst_a_n   = 1'b0;
    req_valid = '0;
    repeat (3) @(posedge clk_a);
    #1 rst_a_n = 1'b1;
  endtask

  function automatic logic pick(input int sel);
    case (sel)
      0:       return xfer_req;
      1:       return busy;
      default: return xfer_done;
    endcase
  endfunction

  task automatic wait_for(input string name, input int sel, input logic val, input int limit);
    int n;
    n = 0;
    @(negedge clk_a);
    while (pick(sel) !== val && n < limit) begin
      @(negedge clk_a);
      n++;
    end
    check(name, 32'(pick(sel)), 32'(val));
  endtask

  task automatic wait_grants(input string name, input int target, input int limit);
    int n;
    n = 0;
    while (grants_seen < target && n < limit) begin
      @(negedge clk_a);
      n++;
    end
    check(name, grants_seen, target);
  endtask

  // Called while in REQ_HI: run the ack high/low handshake by hand.
  task automatic finish_manual(input string tag);
    manual_ack = 1'b1;
    wait_for({tag, "_req_fall"}, 0, 1'b0, 20);
    manual_ack = 1'b0;
    wait_for({tag, "_done"}, 2, 1'b1, 20);
  endtask

  function automatic logic [SRC_W-1:0] rr_pick(input logic [NUM_REQ-1:0] v, input logic [SRC_W-1:0] p);
    for (int k = 0; k < NUM_REQ; k++) begin
      logic [SRC_W-1:0] i;
      i = p + SRC_W'(k);
      if (v[i]) return i;
    end
    return p;
  endfunction

  initial begin
    logic [NUM_REQ-1:0]        v;
    logic [NUM_REQ*DATA_W-1:0] d;
    logic [SRC_W-1:0]          w;
    logic [SRC_W-1:0]          ptr_m;

    rst_a_n    = 1'b0;
    req_valid  = '0;
    req_data   = '0;
    manual_ack = 1'b0;
    resp_en    = 1'b0;
    resp_delay = 3;

    // Reset values
    @(negedge clk_a);
    check("rst_req", 32'(xfer_req), 32'd0);
    check("rst_data", 32'(xfer_data), 32'd0);
    check("rst_src", 32'(xfer_src), 32'd0);
    check("rst_done", 32'(xfer_done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);

    // Single request from requester 2, then payload change while busy
    tick();
    rst_a_n   = 1'b1;
    req_data  = {8'h44, 8'hA5, 8'h22, 8'h11};
    req_valid = 4'b0100;
    exp_q.push_back('{src: 2'd2, data: 8'hA5});
    @(negedge clk_a);
    check("t1_ready", 32'(req_ready), 32'b0100);
    check("t1_req_before", 32'(xfer_req), 32'd0);
    tick();
    req_valid          = '0;
    req_data[23:16]    = 8'h5A;
    @(negedge clk_a);
    check("t1_req", 32'(xfer_req), 32'd1);
    check("t1_data", 32'(xfer_data), 32'hA5);
    check("t1_src", 32'(xfer_src), 32'd2);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_ready_busy", 32'(req_ready), 32'd0);
    finish_manual("t1");
    check("t4_data_after_done", 32'(xfer_data), 32'hA5);
    @(negedge clk_a);
    check("t1_done_count", dones_seen, 1);

    // All requesters valid, responder with 3-cycle delay: grants rotate 0,1,2,3,0
    do_reset();
    grants_seen = 0;
    dones_seen  = 0;
    resp_en     = 1'b1;
    resp_delay  = 3;
    req_data    = {8'h43, 8'h42, 8'h41, 8'h40};
    exp_q.push_back('{src: 2'd0, data: 8'h40});
    exp_q.push_back('{src: 2'd1, data: 8'h41});
    exp_q.push_back('{src: 2'd2, data: 8'h42});
    exp_q.push_back('{src: 2'd3, data: 8'h43});
    exp_q.push_back('{src: 2'd0, data: 8'h40});
    req_valid = 4'b1111;
    wait_grants("t2_grants", 5, 400);
    tick();
    req_valid = '0;
    wait_for("t2_idle", 1, 1'b0, 200);
    @(negedge clk_a);
    @(negedge clk_a);
    check("t2_done_count", dones_seen, 5);
    check("t2_queue_empty", exp_q.size(), 0);
    resp_en = 1'b0;

    // Stale high ack blocks grants until ack_s falls, 2 cycles after ack_b
    manual_ack = 1'b1;
    do_reset();
    repeat (3) tick();
    req_data  = {8'h00, 8'h00, 8'h00, 8'hC3};
    exp_q.push_back('{src: 2'd0, data: 8'hC3});
    req_valid = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_a);
      check("t3_blocked", 32'(req_ready), 32'd0);
    end
    tick();
    manual_ack = 1'b0;
    @(negedge clk_a);
    check("t3_ready_n0", 32'(req_ready), 32'd0);
    @(negedge clk_a);
    check("t3_ready_n1", 32'(req_ready), 32'd0);
    @(negedge clk_a);
    check("t3_ready_n2", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    @(negedge clk_a);
    check("t3_req", 32'(xfer_req), 32'd1);
    finish_manual("t3");

    // Reset in REQ_HI: outputs clear at once, pointer restarts at 0
    do_reset();
    req_data  = {8'h00, 8'h00, 8'hB7, 8'h00};
    exp_q.push_back('{src: 2'd1, data: 8'hB7});
    req_valid = 4'b0010;
    wait_for("t5_req_hi", 0, 1'b1, 10);
    #2 rst_a_n = 1'b0;
    #1;
    check("t5_rst_req", 32'(xfer_req), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_data", 32'(xfer_data), 32'd0);
    @(posedge clk_a);
    #1;
    req_data  = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
    req_valid = 4'b1111;
    exp_q.push_back('{src: 2'd0, data: 8'hD0});
    rst_a_n   = 1'b1;
    wait_for("t5_req_after", 0, 1'b1, 10);
    check("t5_src_after", 32'(xfer_src), 32'd0);
    req_valid = '0;
    finish_manual("t5");

    // Random valid patterns, payloads and ack delays with a round-robin reference
    do_reset();
    grants_seen = 0;
    dones_seen  = 0;
    resp_en     = 1'b1;
    ptr_m       = '0;
    for (int n = 0; n < N_RAND; n++) begin
      v = NUM_REQ'($urandom_range(1, 15));
      d = $urandom;
      w = rr_pick(v, ptr_m);
      exp_q.push_back('{src: w, data: d[int'(w)*DATA_W +: DATA_W]});
      ptr_m      = w + 1'b1;
      resp_delay = $urandom_range(0, 4);
      req_valid  = v;
      req_data   = d;
      wait_grants("t6_grant", n + 1, 400);
      tick();
    end
    req_valid = '0;
    wait_for("t6_idle", 1, 1'b0, 400);
    @(negedge clk_a);
    @(negedge clk_a);
    check("t6_done_count", dones_seen, N_RAND);
    check("t6_queue_empty", exp_q.size(), 0);
    resp_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
